prf_wb_arbiter: RTL and testbench
=================================

# prf_wb_arbiter

Write-back arbiter for the physical register file's single write port. Up to NUM_REQ functional units (ALU, load/store, mul/div, hi/lo mover) present completed results with a valid/ready handshake. One result per cycle is granted by round-robin priority and registered onto the write port (Write1/WriteReg1/WriteData1) and the wakeup broadcast. Sits between the execute-stage units and RegRead/PhysRegFile.

## Interface
- NUM_PHYS_REGS, 64, physical register count; LOG_PHYS = $clog2(NUM_PHYS_REGS)
- NUM_REQ, 4, number of requesters, 2..8
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester result valid
- req_reg  in  NUM_REQ*LOG_PHYS  destination physical tag; requester i occupies bits [i*LOG_PHYS +: LOG_PHYS]
- req_data  in  NUM_REQ*32  result data; requester i occupies bits [i*32 +: 32]
- req_ready  out  NUM_REQ  per-requester grant, combinational
- stall  in  1  write port borrowed this cycle (commit/hi-lo path); blocks all grants
- flush  in  1  pipeline flush; blocks all grants and kills the registered output
- Write1  out  1  PRF write enable; wakeup valid
- WriteReg1  out  LOG_PHYS  PRF write tag; wakeup tag
- WriteData1  out  32  PRF write data
- wb_src  out  $clog2(NUM_REQ)  index of the requester that produced the current write
- conflict_cnt  out  32  saturating count of cycles with ≥2 valid requests

## Operation
- Round-robin pointer ptr, range 0..NUM_REQ-1.
- Winner: the first i with req_valid[i]=1, searching ptr, ptr+1, … modulo NUM_REQ.
- grant_en = |req_valid & !stall & !flush.
- req_ready[i] = grant_en & (i == winner). At most one bit is set.
- req_ready depends combinationally on req_valid. Requesters must not derive req_valid from req_ready.
- A transfer occurs when req_valid[i] & req_ready[i]. The requester drops the result or presents its next one in the following cycle.
- On a transfer, at the clock edge:
  - Write1 ← 1
  - WriteReg1 ← req_reg[winner]
  - WriteData1 ← req_data[winner]
  - wb_src ← winner
  - ptr ← (winner+1) mod NUM_REQ
- No transfer: Write1 ← 0. WriteReg1, WriteData1 and wb_src hold. ptr holds.
- flush: Write1 ← 0 at the next edge, with or without a pending request. ptr holds.
- stall: identical to flush for grant and output purposes.
- conflict_cnt increments on every cycle where popcount(req_valid) ≥ 2, regardless of stall/flush. It saturates at 0xFFFFFFFF.
- No tag filtering. Tag 0 is written like any other tag.
- Reset (RESET=0, asynchronous), all outputs and state go to:
  - Write1=0, WriteReg1=0, WriteData1=0, wb_src=0, conflict_cnt=0, ptr=0
  - req_ready=0 while RESET is low
  - Assertion mid-cycle kills any in-flight write immediately.

## Timing
- Latency: a request accepted in cycle N appears on Write1/WriteReg1/WriteData1 in cycle N+1. PhysRegFile commits it at the end of N+1.
- Throughput: 1 write per cycle sustained, regardless of how many requesters are active.
- Fairness: a continuously valid requester is granted within NUM_REQ non-stalled cycles.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr=0.
- stall or flush in cycle N: no req_ready in N, Write1=0 in N+1. A write registered in N-1 is still driven in N.
- Reset deassertion: first grant possible in the first cycle RESET is sampled high.

## Test plan
- Reset: hold RESET=0 with all req_valid=1 → req_ready=0, Write1=0, conflict_cnt=0. Release → requester 0 granted first.
- Single requester: req_valid=4'b0100, reg=0x2A, data=0xDEADBEEF in cycle N → req_ready=4'b0100 in N; in N+1 Write1=1, WriteReg1=0x2A, WriteData1=0xDEADBEEF, wb_src=2.
- Round-robin: all four valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; Write1=1 every cycle from cycle 1; conflict_cnt=8.
- Skip/wrap: ptr=3, req_valid=4'b0011 → grant 0, then 1, then 0.
- Stall/flush: all valid, stall=1 in cycle 2 and flush=1 in cycle 4 → no req_ready in 2 or 4; Write1=0 in 3 and 5; ptr unchanged across both.
- Async reset mid-stream: RESET falls between edges while Write1=1 → Write1=0 immediately; after release, grants resume from requester 0.

Source files
------------

// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter: round-robin write-back arbiter for the PRF's single write port
// Ports: CLK/RESET (async, active-low); req_valid/req_reg/req_data in, req_ready out (combinational grant);
// stall/flush block grants; Write1/WriteReg1/WriteData1 registered write port + wakeup; wb_src winner index;
// conflict_cnt saturating count of cycles with two or more valid requests.
module prf_wb_arbiter #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_REQ = 4,
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS),
  localparam int SRC_W = $clog2(NUM_REQ)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LOG_PHYS-1:0]  req_reg,
  input  logic [NUM_REQ*32-1:0]        req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         Write1,
  output logic [LOG_PHYS-1:0]          WriteReg1,
  output logic [31:0]                  WriteData1,
  output logic [SRC_W-1:0]             wb_src,
  output logic [31:0]                  conflict_cnt
);
  logic [SRC_W-1:0]    r_ptr;
  logic                r_write;
  logic [LOG_PHYS-1:0] r_reg;
  logic [31:0]         r_data;
  logic [SRC_W-1:0]    r_src;
  logic [31:0]         r_cnt;
  logic [SRC_W-1:0]    w_win;
  logic                w_grant;
  // Scan from farthest to nearest so the valid requester closest to ptr is written last and wins.
  always_comb begin
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) w_win = SRC_W'((int'(r_ptr) + k) % NUM_REQ);
  end
  // RESET gates the grant so nothing is accepted while reset is held low.
  assign w_grant   = RESET & (|req_valid) & ~stall & ~flush;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ptr   <= '0;
      r_write <= 1'b0;
      r_reg   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_cnt   <= '0;
    end else begin
      r_write <= w_grant;
      if (w_grant) begin
        r_reg  <= req_reg[int'(w_win)*LOG_PHYS +: LOG_PHYS];
        r_data <= req_data[int'(w_win)*32 +: 32];
        r_src  <= w_win;
        r_ptr  <= (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
      if ($countones(req_valid) > 1 && ~&r_cnt) r_cnt <= r_cnt + 32'd1;
    end
  end
  assign Write1       = r_write;
  assign WriteReg1    = r_reg;
  assign WriteData1   = r_data;
  assign wb_src       = r_src;
  assign conflict_cnt = r_cnt;
endmodule

// File: tb/tb_prf_wb_arbiter.sv
// tb_prf_wb_arbiter: directed and randomized checks of prf_wb_arbiter against a distance-based reference model
module tb_prf_wb_arbiter;
  localparam int N = 4;
  localparam int LP = 6;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*LP-1:0] req_reg = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic            write1;
  logic [LP-1:0]   write_reg1;
  logic [31:0]     write_data1;
  logic [1:0]      wb_src;
  logic [31:0]     conflict_cnt;
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  logic m_w = 1'b0;
  logic [LP-1:0] m_reg = '0;
  logic [31:0] m_data = '0;
  int m_src = 0;
  logic [31:0] m_cnt = '0;
  prf_wb_arbiter #(.NUM_PHYS_REGS(64), .NUM_REQ(N)) dut (
    .CLK(clk), .RESET(rst_n), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .stall(stall), .flush(flush), .Write1(write1), .WriteReg1(write_reg1),
    .WriteData1(write_data1), .wb_src(wb_src), .conflict_cnt(conflict_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Winner = valid requester at the smallest forward distance from the pointer.
  function automatic int model_winner(input logic [N-1:0] v, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_w = 0; m_reg = '0; m_data = '0; m_src = 0; m_cnt = '0;
  endtask
  // Inputs are set just after a rising edge; ready is checked at the falling edge, outputs 1ns after the next rising edge.
  task automatic step(input string tag);
    int w;
    logic [N-1:0] er;
    w = (!stall && !flush) ? model_winner(req_valid, m_ptr) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_w = 1'b1;
      m_reg = req_reg[w*LP +: LP];
      m_data = req_data[w*32 +: 32];
      m_src = w;
      m_ptr = (w + 1) % N;
    end else m_w = 1'b0;
    if ($countones(req_valid) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    chk({tag, ".write1"}, 64'(write1), 64'(m_w));
    chk({tag, ".wreg"}, 64'(write_reg1), 64'(m_reg));
    chk({tag, ".wdata"}, 64'(write_data1), 64'(m_data));
    chk({tag, ".src"}, 64'(wb_src), 64'(m_src));
    chk({tag, ".cnt"}, 64'(conflict_cnt), 64'(m_cnt));
  endtask
  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      req_reg[i*LP +: LP] = LP'($urandom);
      req_data[i*32 +: 32] = $urandom;
    end
  endtask
  initial begin
    req_valid = '1;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(req_ready), 64'h0);
    chk("rst.write1", 64'(write1), 64'h0);
    chk("rst.cnt", 64'(conflict_cnt), 64'h0);
    chk("rst.wreg", 64'(write_reg1), 64'h0);
    rst_n = 1'b1;
    step("rel");
    chk("rel.first", 64'(wb_src), 64'd0);
    req_valid = 4'b0100;
    req_reg[2*LP +: LP] = 6'h2A;
    req_data[2*32 +: 32] = 32'hDEAD_BEEF;
    step("single");
    chk("single.data", 64'(write_data1), 64'hDEAD_BEEF);
    chk("single.src", 64'(wb_src), 64'd2);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    req_valid = '1;
    fill_random();
    for (int c = 0; c < 8; c++) begin
      step("rr");
      chk("rr.order", 64'(wb_src), 64'(c % N));
    end
    chk("rr.cnt8", 64'(conflict_cnt), 64'd8);
    req_valid = 4'b0100;
    step("toptr3");
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      step("wrap");
      chk("wrap.order", 64'(wb_src), 64'(c % 2));
    end
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      stall = (c == 2);
      flush = (c == 4);
      step(stall ? "stall" : flush ? "flush" : "sf");
    end
    stall = 1'b0;
    flush = 1'b0;
    step("sf.after");
    chk("sf.after.w", 64'(write1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.write1", 64'(write1), 64'h0);
    chk("arst.ready", 64'(req_ready), 64'h0);
    chk("arst.cnt", 64'(conflict_cnt), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("arst.rel");
    chk("arst.first", 64'(wb_src), 64'd0);
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      fill_random();
      stall = ($urandom_range(9) == 0);
      flush = ($urandom_range(9) == 0);
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
